uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. Bytes written through a valid/ready port are
//   queued in a circular FIFO and serialised LSB-first on dout as
//   start / data / [parity] / stop frames. Bit timing comes from a
//   free-running baud counter that produces a one-cycle tick enable on
//   clk_100MHz; there are no derived clocks.
//
//   Optional build macro: UART_TX_PARITY_EN
//     defined   -> an even-parity bit (XOR of the data bits) follows the data
//     undefined -> no parity bit; the PARITY state does not exist
//
// Ports
//   clk_100MHz  in   system clock
//   reset       in   synchronous, active-high reset
//   din         in   write data (DATA_BITS wide)
//   vdin        in   write valid; accepted when vdin && din_ready
//   din_ready   out  FIFO not full
//   dout        out  serial line, idles high
//   busy        out  frame in progress or FIFO non-empty
//   fifo_count  out  FIFO occupancy (DEPTH_LOG2+1 bits)
//   overflow    out  sticky: a write was attempted while the FIFO was full
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_DIV    = 10416,
  parameter int DATA_BITS  = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [DATA_BITS-1:0]  din,
  input  logic                  vdin,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction
`endif

  // Baud generator
  logic [CNT_W-1:0]      baud_cnt_r;
  logic                  tick_s;

  // FIFO
  logic [DATA_BITS-1:0]  mem_r [DEPTH];
  logic [DEPTH_LOG2:0]   wptr_r;
  logic [DEPTH_LOG2:0]   rptr_r;
  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_BITS-1:0]  rd_data_s;
  logic                  overflow_r;

  // Transmit FSM
  state_t                state_r;
  state_t                state_n;
  logic                  dout_r;
  logic                  dout_n;
  logic [DATA_BITS-1:0]  shift_r;
  logic [DATA_BITS-1:0]  shift_n;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_n;
  logic                  stop_r;
  logic                  stop_n;
`ifdef UART_TX_PARITY_EN
  logic                  parity_r;
  logic                  parity_n;
`endif

  assign tick_s = (baud_cnt_r == CNT_W'(CLK_DIV - 1));

  // Full uses the extra pointer MSB to tell a wrapped writer from an empty FIFO.
  assign empty_s    = (wptr_r == rptr_r);
  assign full_s     = (wptr_r[DEPTH_LOG2-1:0] == rptr_r[DEPTH_LOG2-1:0]) &&
                      (wptr_r[DEPTH_LOG2] != rptr_r[DEPTH_LOG2]);
  assign push_s     = vdin && !full_s;
  assign rd_data_s  = mem_r[rptr_r[DEPTH_LOG2-1:0]];

  assign din_ready  = !full_s;
  assign fifo_count = wptr_r - rptr_r;
  assign busy       = (state_r != ST_IDLE) || !empty_s;
  assign dout       = dout_r;
  assign overflow   = overflow_r;

  // Free-running baud counter; never restarted per frame.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      baud_cnt_r <= CNT_W'(0);
    end else if (tick_s) begin
      baud_cnt_r <= CNT_W'(0);
    end else begin
      baud_cnt_r <= baud_cnt_r + CNT_W'(1);
    end
  end

  // FIFO storage; contents are deliberately left unreset.
  always_ff @(posedge clk_100MHz) begin
    if (push_s) begin
      mem_r[wptr_r[DEPTH_LOG2-1:0]] <= din;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wptr_r     <= {(DEPTH_LOG2+1){1'b0}};
      rptr_r     <= {(DEPTH_LOG2+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rptr_r <= rptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end
      if (vdin && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FSM next-state and datapath; every transition is gated by the baud tick.
  always_comb begin
    state_n  = state_r;
    dout_n   = dout_r;
    shift_n  = shift_r;
    idx_n    = idx_r;
    stop_n   = stop_r;
    pop_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n = parity_r;
`endif
    if (tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            pop_s    = 1'b1;
            shift_n  = rd_data_s;
`ifdef UART_TX_PARITY_EN
            parity_n = even_parity(rd_data_s);
`endif
            dout_n   = 1'b0;
            state_n  = ST_START;
          end else begin
            dout_n   = 1'b1;
          end
        end
        ST_START: begin
          dout_n  = shift_r[0];
          shift_n = {1'b0, shift_r[DATA_BITS-1:1]};
          idx_n   = IDX_W'(0);
          state_n = ST_DATA;
        end
        ST_DATA: begin
          if (idx_r == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            dout_n  = parity_r;
            state_n = ST_PARITY;
`else
            dout_n  = 1'b1;
            stop_n  = 1'b0;
            state_n = ST_STOP;
`endif
          end else begin
            dout_n  = shift_r[0];
            shift_n = {1'b0, shift_r[DATA_BITS-1:1]};
            idx_n   = idx_r + IDX_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          dout_n  = 1'b1;
          stop_n  = 1'b0;
          state_n = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (stop_r == 1'(STOP_BITS - 1)) begin
            // Last stop bit ends: start the next frame on this very tick so
            // consecutive frames have no idle bit between them.
            if (!empty_s) begin
              pop_s    = 1'b1;
              shift_n  = rd_data_s;
`ifdef UART_TX_PARITY_EN
              parity_n = even_parity(rd_data_s);
`endif
              dout_n   = 1'b0;
              state_n  = ST_START;
            end else begin
              dout_n   = 1'b1;
              state_n  = ST_IDLE;
            end
          end else begin
            dout_n = 1'b1;
            stop_n = 1'b1;
          end
        end
        default: begin
          dout_n  = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // FSM and shift-register state; reset returns the line high at once.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      dout_r   <= 1'b1;
      shift_r  <= {DATA_BITS{1'b0}};
      idx_r    <= IDX_W'(0);
      stop_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_n;
      dout_r   <= dout_n;
      shift_r  <= shift_n;
      idx_r    <= idx_n;
      stop_r   <= stop_n;
`ifdef UART_TX_PARITY_EN
      parity_r <= parity_n;
`endif
    end
  end

endmodule
